muldiv_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit replacing separate fixed-32-bit Mult/Div blocks.

---
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiply / restoring divide unit, WIDTH-bit operands.
// Define MULDIV_UNSIGNED_EN to enable multu/divu on op[1].
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNTW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    RUN,
    FIX
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNTW-1:0]    cnt;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   sh;
  logic               is_div;
  logic               sgn_r;
  logic               neg_q;
  logic               neg_r;
  logic               dz_pend;

  logic               op_div;
  logic               op_sgn;
  logic               accept;
  logic               dz;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rsh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_n;

  assign op_div = op[0];

`ifdef MULDIV_UNSIGNED_EN
  assign op_sgn = ~op[1];
`else
  logic unused_op;
  assign unused_op = op[1];
  assign op_sgn    = 1'b1;
  assign sgn_r     = 1'b1;
`endif

  // A div-by-zero completes from IDLE; block new starts until its pulse.
  assign accept = (state == IDLE) && start && !dz_pend;
  assign dz     = op_div && (b == '0);
  assign busy   = (state != IDLE);

  assign mag_a  = (sgn_r && a_r[WIDTH-1]) ? -a_r : a_r;
  assign mag_b  = (sgn_r && b_r[WIDTH-1]) ? -b_r : b_r;

  assign addend = sh[0] ? b_r : '0;
  assign sum    = {1'b0, acc} + {1'b0, addend};
  assign rsh    = {acc, sh[WIDTH-1]};
  assign diff   = rsh - {1'b0, b_r};

  assign prod   = {acc, sh};
  assign prod_n = neg_q ? -prod : prod;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept && !dz) state_nx = PREP;
      PREP: state_nx = RUN;
      RUN:  if (cnt == CNTW'(1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef MULDIV_UNSIGNED_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      sgn_r <= 1'b0;
    end else if (accept) begin
      sgn_r <= op_sgn;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      sh      <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_pend <= 1'b0;
      done    <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done    <= 1'b0;
      dz_pend <= 1'b0;
      if (dz_pend) begin
        done <= 1'b1;
        div0 <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_r     <= a;
            b_r     <= b;
            is_div  <= op_div;
            div0    <= 1'b0;
            dz_pend <= dz;
          end
        end
        PREP: begin
          sh    <= mag_a;
          b_r   <= mag_b;
          acc   <= '0;
          cnt   <= CNTW'(WIDTH);
          neg_q <= sgn_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          neg_r <= sgn_r & a_r[WIDTH-1];
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            if (!diff[WIDTH]) begin
              acc <= diff[WIDTH-1:0];
              sh  <= {sh[WIDTH-2:0], 1'b1};
            end else begin
              acc <= rsh[WIDTH-1:0];
              sh  <= {sh[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= sum[WIDTH:1];
            sh  <= {sum[0], sh[WIDTH-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (is_div) begin
            lo <= neg_q ? -sh : sh;
            hi <= neg_r ? -acc : acc;
          end else begin
            {hi, lo} <= prod_n;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic        div08;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock(clk), .reset(rst), .start(start),
    .op(op), .a(a), .b(b), .busy(busy),
    .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) u8 (
    .clock(clk), .reset(rst), .start(start8),
    .op(op8), .a(a8), .b(b8), .busy(busy8),
    .done(done8), .div0(div08), .hi(hi8), .lo(lo8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on w-bit values; returns {hi,lo}.
  function automatic logic [63:0] ref_op(
    input int w, input logic [1:0] o,
    input logic [31:0] x, input logic [31:0] y
  );
    logic [63:0] mask, ua, ub, q, r, p;
    longint sa, sb;
    logic sg;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'b0, x} & mask;
    ub = {32'b0, y} & mask;
    sa = $signed(ua << (64 - w)) >>> (64 - w);
    sb = $signed(ub << (64 - w)) >>> (64 - w);
`ifdef MULDIV_UNSIGNED_EN
    sg = !o[1];
`else
    sg = 1'b1;
`endif
    if (!o[0]) begin
      p = sg ? 64'(sa * sb) : ua * ub;
      q = p & mask;
      r = (p >> w) & mask;
    end else if (sg) begin
      q = 64'(sa / sb) & mask;
      r = 64'(sa % sb) & mask;
    end else begin
      q = (ua / ub) & mask;
      r = (ua % ub) & mask;
    end
    return {r[31:0], q[31:0]};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    start8 = 1'b0;
    op = 2'b00; a = '0; b = '0;
    op8 = 2'b00; a8 = '0; b8 = '0;
    tick;
    tick;
    total++;
    if ({busy, done, div0} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=000",
               {busy, done, div0});
    end
    total++;
    if ({hi, lo} !== 64'd0) begin
      bad++;
      $display("FAIL reset_hilo got=%h exp=0", {hi, lo});
    end
    total++;
    if ({busy8, done8, div08, hi8, lo8} !== 19'd0) begin
      bad++;
      $display("FAIL reset_w8 got=%h exp=0",
               {busy8, done8, div08, hi8, lo8});
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_arith;
    logic [1:0]  oq[$];
    logic [31:0] aq[$];
    logic [31:0] bq[$];
    logic [63:0] exp;
    int k;
    oq = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    aq = '{32'd3, 32'hFFFFFFF9, 32'h80000000,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    bq = '{32'hFFFFFFFC, 32'd2, 32'hFFFFFFFF,
           32'hFFFFFFFF, 32'd7, 32'h80000000};
    for (int n = 0; n < 24; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 2) == 0)
        rb = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0)
        rb = -rb;
      if (ro[0] && rb == 0) rb = 32'd1;
      oq.push_back(ro);
      aq.push_back(ra);
      bq.push_back(rb);
    end
    for (int i = 0; i < oq.size(); i++) begin
      exp = ref_op(32, oq[i], aq[i], bq[i]);
      if (i == 0 && exp !== 64'hFFFFFFFF_FFFFFFF4)
        $display("note: model disagrees with case 1");
      op = oq[i]; a = aq[i]; b = bq[i];
      start = 1'b1;
      tick;
      start = 1'b0;
      a = $urandom; b = $urandom;
      op = 2'($urandom_range(0, 3));
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL arith[%0d] busy got=%b exp=1", i, busy);
      end
      for (k = 1; k <= 40; k++) begin
        tick;
        if (done === 1'b1) break;
      end
      total++;
      if (k !== 34) begin
        bad++;
        $display("FAIL arith[%0d] latency got=%0d exp=34", i, k);
      end
      total++;
      if ({hi, lo} !== exp) begin
        bad++;
        $display("FAIL arith[%0d] op=%0d hilo got=%h exp=%h",
                 i, oq[i], {hi, lo}, exp);
      end
      total++;
      if ({div0, busy} !== 2'b00) begin
        bad++;
        $display("FAIL arith[%0d] div0/busy got=%b exp=00",
                 i, {div0, busy});
      end
      tick;
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL arith[%0d] done_len got=%b exp=0", i, done);
      end
    end
  endtask

  task automatic test_div0;
    logic [63:0] prev;
    int k;
    prev = {hi, lo};
    op = 2'b01; a = $urandom; b = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    b = $urandom | 32'd1;
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL div0_e0 busy/done got=%b exp=00",
               {busy, done});
    end
    tick;
    total++;
    if ({done, div0, busy} !== 3'b110) begin
      bad++;
      $display("FAIL div0_pulse got=%b exp=110",
               {done, div0, busy});
    end
    total++;
    if ({hi, lo} !== prev) begin
      bad++;
      $display("FAIL div0_hold got=%h exp=%h", {hi, lo}, prev);
    end
    tick;
    total++;
    if ({done, div0} !== 2'b01) begin
      bad++;
      $display("FAIL div0_after got=%b exp=01", {done, div0});
    end
    op = 2'b00; a = 32'd5; b = 32'd7;
    start = 1'b1;
    tick;
    start = 1'b0;
    total++;
    if ({div0, busy} !== 2'b01) begin
      bad++;
      $display("FAIL div0_clear got=%b exp=01", {div0, busy});
    end
    for (k = 1; k <= 40; k++) begin
      tick;
      if (done === 1'b1) break;
    end
    total++;
    if (k !== 34 || {hi, lo} !== 64'd35) begin
      bad++;
      $display("FAIL div0_next k=%0d hilo got=%h exp=34/23",
               k, {hi, lo});
    end
    tick;
  endtask

  task automatic test_ignore_start;
    logic [63:0] exp;
    logic [31:0] a1, b1;
    int k;
    a1 = $urandom;
    b1 = $urandom_range(1, 1000);
    exp = ref_op(32, 2'b01, a1, b1);
    op = 2'b01; a = a1; b = b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    op = 2'b00; a = $urandom; b = $urandom;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (k = 6; k <= 40; k++) begin
      tick;
      if (done === 1'b1) break;
    end
    total++;
    if (k !== 34) begin
      bad++;
      $display("FAIL ignore latency got=%0d exp=34", k);
    end
    total++;
    if ({hi, lo} !== exp) begin
      bad++;
      $display("FAIL ignore hilo got=%h exp=%h", {hi, lo}, exp);
    end
    tick;
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL ignore idle got=%b exp=00", {busy, done});
    end
  endtask

  task automatic test_abort;
    logic seen;
    op = 2'b00; a = $urandom; b = $urandom;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++;
    if ({busy, done, div0, hi, lo} !== 67'd0) begin
      bad++;
      $display("FAIL abort got=%h exp=0",
               {busy, done, div0, hi, lo});
    end
    seen = 1'b0;
    repeat (40) begin
      tick;
      if (done === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || {hi, lo} !== 64'd0) begin
      bad++;
      $display("FAIL abort_nodone seen=%b hilo got=%h exp=0/0",
               seen, {hi, lo});
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp;
    logic [1:0]  o;
    int k;
    o = 2'($urandom_range(0, 3));
    op = o; a = $urandom; b = $urandom | 32'd1;
    exp = ref_op(32, o, a, b);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      for (k = 1; k <= 40; k++) begin
        tick;
        if (done === 1'b1) break;
      end
      total++;
      if (k !== 34 || {hi, lo} !== exp) begin
        bad++;
        $display("FAIL b2b[%0d] k=%0d hilo got=%h exp=%h",
                 n, k, {hi, lo}, exp);
      end
      o = 2'($urandom_range(0, 3));
      op = o; a = $urandom; b = $urandom | 32'd1;
      exp = ref_op(32, o, a, b);
      start = (n < 2);
      tick;
      start = 1'b0;
    end
  endtask

  task automatic test_w8;
    logic [63:0] r;
    logic [15:0] exp;
    logic [1:0]  o;
    int k;
    exp = 16'h3F01;
    op8 = 2'b00; a8 = 8'h7F; b8 = 8'h7F;
    start8 = 1'b1;
    tick;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    for (int n = 0; n < 12; n++) begin
      for (k = 1; k <= 20; k++) begin
        tick;
        if (done8 === 1'b1) break;
      end
      total++;
      if (k !== 10) begin
        bad++;
        $display("FAIL w8[%0d] latency got=%0d exp=10", n, k);
      end
      total++;
      if ({hi8, lo8} !== exp) begin
        bad++;
        $display("FAIL w8[%0d] hilo got=%h exp=%h",
                 n, {hi8, lo8}, exp);
      end
      o = 2'($urandom_range(0, 3));
      op8 = o; a8 = 8'($urandom); b8 = 8'($urandom);
      if (o[0] && b8 == 8'd0) b8 = 8'd3;
      r = ref_op(8, o, {24'b0, a8}, {24'b0, b8});
      exp = {r[39:32], r[7:0]};
      start8 = (n < 11);
      tick;
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_div0();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_w8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
